// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory port arbiter.
//   state_e             - arbiter FSM states (IDLE: may grant, WAIT: read outstanding)
//   owner_e             - which requester owns the outstanding read
//   MMIO_BASE_DEFAULT   - byte address of the seven-segment display word
//   mem_word_addr()     - 32-bit byte address -> 20-bit memory word address
package mem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

   // Bit 31 selects the upper (MMIO) half of the memory; bits 19:1 give the word.
   // The other address bits do not reach the memory.
   function automatic logic [19:0] mem_word_addr(input logic [31:0] addr);
      logic unused_bits;
      unused_bits = ^{addr[30:20], addr[0]};
      return {addr[31], addr[19:1]};
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk_i, rst_n_i - clock, synchronous active-low reset
//   en_i           - arbitration allowed this cycle
//   req_i[1:0]     - requests, [0] = IF, [1] = LS
//   gnt_o[1:0]     - one-hot grant (combinational), same bit order
// The priority register names the requester that wins a tie; it resets to LS
// and moves to the other requester whenever a grant is issued.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   owner_e prio_q, prio_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (req_i == 2'b11) begin
            gnt_o = (prio_q == OWN_LS) ? 2'b10 : 2'b01;
         end else begin
            gnt_o = req_i;
         end
      end
   end

   always_comb begin
      prio_d = prio_q;
      if (gnt_o[0]) begin
         prio_d = OWN_LS;
      end else if (gnt_o[1]) begin
         prio_d = OWN_IF;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         prio_q <= OWN_LS;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between instruction fetch (IF)
// and load/store (LS), one read outstanding at a time, and decodes the display
// MMIO word.
//   Parameters: MEM_LAT (read latency, 1..4), MMIO_BASE (display word address)
//   clk_i, rst_n_i           - clock, synchronous active-low reset
//   if_req_i/if_addr_i       - IF read request, held until if_gnt_o
//   if_gnt_o/if_rvalid_o/if_rdata_o - IF accept, read-data pulse and data
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i - LS request, held until ls_gnt_o
//   ls_gnt_o/ls_rvalid_o/ls_rdata_o - LS accept, read-data pulse and data
//   mem_addr_o/mem_wdata_o/mem_wen_o/mem_ren_o - memory port (grant cycle only)
//   mem_rdata_i              - memory data, valid MEM_LAT cycles after mem_ren_o
//   disp_wen_o/disp_data_o   - display register write pulse and held data
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned  MEM_LAT   = 1,
   parameter logic [31:0]  MMIO_BASE = MMIO_BASE_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        ls_req_i,
   input  logic        ls_we_i,
   input  logic [31:0] ls_addr_i,
   input  logic [31:0] ls_wdata_i,
   output logic        ls_gnt_o,
   output logic        ls_rvalid_o,
   output logic [31:0] ls_rdata_o,
   output logic [19:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_wen_o,
   output logic        mem_ren_o,
   input  logic [31:0] mem_rdata_i,
   output logic        disp_wen_o,
   output logic [31:0] disp_data_o
);

   localparam logic [2:0] LAT_C = 3'(MEM_LAT);

   state_e      state_q;
   owner_e      owner_q;
   logic [2:0]  cnt_q;
   logic        if_rvalid_q, ls_rvalid_q;
   logic [31:0] if_rdata_q, ls_rdata_q;
   logic        disp_wen_q;
   logic [31:0] disp_data_q;

   logic [1:0]  gnt;
   logic        arb_en;
   logic        ls_wr, rd_start, mmio_hit_d;

   // Gating with reset keeps the combinational grant path at 0 while in reset.
   assign arb_en = rst_n_i && (state_q == IDLE);

   rr_arb2 u_arb (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (arb_en),
      .req_i   ({ls_req_i, if_req_i}),
      .gnt_o   (gnt)
   );

   assign ls_wr      = gnt[1] && ls_we_i;
   assign rd_start   = gnt[0] || (gnt[1] && !ls_we_i);
   assign mmio_hit_d = ls_wr && (ls_addr_i == MMIO_BASE);

   assign if_gnt_o    = gnt[0];
   assign ls_gnt_o    = gnt[1];
   assign mem_wen_o   = ls_wr;
   assign mem_ren_o   = rd_start;
   assign mem_wdata_o = ls_wr ? ls_wdata_i : 32'h0;

   always_comb begin
      mem_addr_o = 20'h0;
      if (gnt[1]) begin
         mem_addr_o = mem_word_addr(ls_addr_i);
      end else if (gnt[0]) begin
         mem_addr_o = mem_word_addr(if_addr_i);
      end
   end

   // cnt_q counts cycles since the grant: it is 1 in the first WAIT cycle, so
   // cnt_q == MEM_LAT is the cycle in which mem_rdata_i is valid.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         cnt_q       <= 3'd0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= 32'h0;
         ls_rdata_q  <= 32'h0;
         disp_wen_q  <= 1'b0;
         disp_data_q <= 32'h0;
      end else begin
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         disp_wen_q  <= mmio_hit_d;
         if (mmio_hit_d) begin
            disp_data_q <= ls_wdata_i;
         end
         case (state_q)
            IDLE: begin
               if (rd_start) begin
                  state_q <= WAIT;
                  owner_q <= gnt[1] ? OWN_LS : OWN_IF;
                  cnt_q   <= 3'd1;
               end
            end
            WAIT: begin
               if (cnt_q == LAT_C) begin
                  state_q <= IDLE;
                  cnt_q   <= 3'd0;
                  if (owner_q == OWN_LS) begin
                     ls_rdata_q  <= mem_rdata_i;
                     ls_rvalid_q <= 1'b1;
                  end else begin
                     if_rdata_q  <= mem_rdata_i;
                     if_rvalid_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_rvalid_o = if_rvalid_q;
   assign ls_rvalid_o = ls_rvalid_q;
   assign if_rdata_o  = if_rdata_q;
   assign ls_rdata_o  = ls_rdata_q;
   assign disp_wen_o  = disp_wen_q;
   assign disp_data_o = disp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT = 1, 2, 3) share one
// stimulus; each vector checks the full output set of one chosen instance.
// Each instance has its own memory model returning data exactly MEM_LAT
// cycles after mem_ren and a poison value in every other cycle.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
   logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;

   logic [2:0]  if_gnt, ls_gnt, if_rv, ls_rv, mem_ren, mem_wen, disp_wen;
   logic [19:0] mem_addr [3];
   logic [31:0] mem_wdata [3], mem_rdata [3], if_rdata [3], ls_rdata [3], disp_data [3];

   function automatic logic [31:0] memfn(input logic [19:0] a);
      return (a == 20'h00008) ? 32'hDEAD_BEEF : {12'hA5A, a};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic [3:0]  vsr;
      logic [19:0] asr [4];

      mem_port_arbiter #(.MEM_LAT(g + 1)) u_dut (
         .clk_i       (clk),
         .rst_n_i     (rst_n),
         .if_req_i    (if_req),
         .if_addr_i   (if_addr),
         .if_gnt_o    (if_gnt[g]),
         .if_rvalid_o (if_rv[g]),
         .if_rdata_o  (if_rdata[g]),
         .ls_req_i    (ls_req),
         .ls_we_i     (ls_we),
         .ls_addr_i   (ls_addr),
         .ls_wdata_i  (ls_wdata),
         .ls_gnt_o    (ls_gnt[g]),
         .ls_rvalid_o (ls_rv[g]),
         .ls_rdata_o  (ls_rdata[g]),
         .mem_addr_o  (mem_addr[g]),
         .mem_wdata_o (mem_wdata[g]),
         .mem_wen_o   (mem_wen[g]),
         .mem_ren_o   (mem_ren[g]),
         .mem_rdata_i (mem_rdata[g]),
         .disp_wen_o  (disp_wen[g]),
         .disp_data_o (disp_data[g])
      );

      always @(posedge clk) begin
         vsr    <= {vsr[2:0], mem_ren[g]};
         asr[0] <= mem_addr[g];
         for (int k = 1; k < 4; k++) asr[k] <= asr[k-1];
      end
      assign mem_rdata[g] = vsr[g] ? memfn(asr[g]) : 32'hBAD0_BAD0;
   end

   // flags = {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_ren, mem_wen, disp_wen}
   typedef struct {
      bit          pre_rst;
      int          g;
      bit          rst;
      bit          ifr;
      logic [31:0] ifa;
      bit          lsr;
      bit          we;
      logic [31:0] lsa;
      logic [31:0] wd;
      logic [6:0]  flags;
      logic [19:0] ma;
      logic [31:0] mwd, ifrd, lsrd, dd;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic logic [154:0] outv(input int g);
      return {if_gnt[g], ls_gnt[g], if_rv[g], ls_rv[g], mem_ren[g], mem_wen[g],
              disp_wen[g], mem_addr[g], mem_wdata[g], if_rdata[g], ls_rdata[g],
              disp_data[g]};
   endfunction

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0;
      repeat (2) @(posedge clk);
   endtask

   task automatic check(input string name, input logic [154:0] act, input logic [154:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   initial begin
      logic [154:0] exp;
      int cyc;

      // A: single IF read, MEM_LAT=1
      tbl.push_back('{1,0,1, 0,32'h0,        0,0,32'h0,0,          7'b0000000,20'h0,    0,0,0,0});
      tbl.push_back('{0,0,1, 1,32'h10,       0,0,32'h0,0,          7'b1000100,20'h00008,0,0,0,0});
      tbl.push_back('{0,0,1, 0,32'h10,       0,0,32'h0,0,          7'b0000000,20'h0,    0,0,0,0});
      tbl.push_back('{0,0,1, 0,32'h10,       0,0,32'h0,0,          7'b0010000,20'h0,    0,32'hDEADBEEF,0,0});
      tbl.push_back('{0,0,1, 0,32'h10,       0,0,32'h0,0,          7'b0000000,20'h0,    0,32'hDEADBEEF,0,0});
      // B: both read every cycle, MEM_LAT=2
      tbl.push_back('{1,1,1, 1,32'h100,      1,0,32'h200,0,        7'b0100100,20'h00100,0,0,0,0});
      tbl.push_back('{0,1,1, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,0,0,0});
      tbl.push_back('{0,1,1, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,0,0,0});
      tbl.push_back('{0,1,1, 1,32'h100,      1,0,32'h200,0,        7'b1001100,20'h00080,0,0,32'hA5A00100,0});
      tbl.push_back('{0,1,1, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,0,32'hA5A00100,0});
      tbl.push_back('{0,1,1, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,0,32'hA5A00100,0});
      tbl.push_back('{0,1,1, 1,32'h100,      1,0,32'h200,0,        7'b0110100,20'h00100,0,32'hA5A00080,32'hA5A00100,0});
      tbl.push_back('{0,1,1, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,32'hA5A00080,32'hA5A00100,0});
      tbl.push_back('{0,1,1, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,32'hA5A00080,32'hA5A00100,0});
      tbl.push_back('{0,1,1, 1,32'h100,      1,0,32'h200,0,        7'b1001100,20'h00080,0,32'hA5A00080,32'hA5A00100,0});
      // C: MMIO write, back-to-back writes, write blocked behind IF read, MMIO read
      tbl.push_back('{1,0,1, 0,32'h0,        1,1,32'h80000000,32'h1234, 7'b0100010,20'h80000,32'h1234,0,0,0});
      tbl.push_back('{0,0,1, 0,32'h0,        1,1,32'h40,32'h55,    7'b0100011,20'h00020,32'h55,0,0,32'h1234});
      tbl.push_back('{0,0,1, 1,32'h10,       1,1,32'h44,32'h66,    7'b1000100,20'h00008,0,0,0,32'h1234});
      tbl.push_back('{0,0,1, 0,32'h0,        1,1,32'h44,32'h66,    7'b0000000,20'h0,    0,0,0,32'h1234});
      tbl.push_back('{0,0,1, 0,32'h0,        1,1,32'h44,32'h66,    7'b0110010,20'h00022,32'h66,32'hDEADBEEF,0,32'h1234});
      tbl.push_back('{0,0,1, 1,32'h20,       1,1,32'h80000000,32'hABCD, 7'b1000100,20'h00010,0,32'hDEADBEEF,0,32'h1234});
      tbl.push_back('{0,0,1, 0,32'h0,        1,1,32'h80000000,32'hABCD, 7'b0000000,20'h0,0,32'hDEADBEEF,0,32'h1234});
      tbl.push_back('{0,0,1, 0,32'h0,        1,1,32'h80000000,32'hABCD, 7'b0110010,20'h80000,32'hABCD,32'hA5A00010,0,32'h1234});
      tbl.push_back('{0,0,1, 0,32'h0,        0,0,32'h0,0,          7'b0000001,20'h0,    0,32'hA5A00010,0,32'hABCD});
      tbl.push_back('{0,0,1, 0,32'h0,        1,0,32'h80000000,0,   7'b0100100,20'h80000,0,32'hA5A00010,0,32'hABCD});
      tbl.push_back('{0,0,1, 0,32'h0,        0,0,32'h0,0,          7'b0000000,20'h0,    0,32'hA5A00010,0,32'hABCD});
      tbl.push_back('{0,0,1, 0,32'h0,        0,0,32'h0,0,          7'b0001000,20'h0,    0,32'hA5A00010,32'hA5A80000,32'hABCD});
      // D: reset during an LS read, MEM_LAT=3
      tbl.push_back('{1,2,1, 0,32'h0,        1,0,32'h200,0,        7'b0100100,20'h00100,0,0,0,0});
      tbl.push_back('{0,2,0, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,0,0,0});
      tbl.push_back('{0,2,0, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,0,0,0});
      tbl.push_back('{0,2,1, 1,32'h100,      1,0,32'h200,0,        7'b0100100,20'h00100,0,0,0,0});
      tbl.push_back('{0,2,1, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,0,0,0});
      tbl.push_back('{0,2,1, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,0,0,0});
      tbl.push_back('{0,2,1, 1,32'h100,      1,0,32'h200,0,        7'b0000000,20'h0,    0,0,0,0});
      tbl.push_back('{0,2,1, 1,32'h100,      1,0,32'h200,0,        7'b1001100,20'h00080,0,0,32'hA5A00100,0});

      foreach (tbl[i]) begin
         if (tbl[i].pre_rst) do_reset();
         @(posedge clk);
         #1;
         rst_n    = tbl[i].rst;
         if_req   = tbl[i].ifr;
         if_addr  = tbl[i].ifa;
         ls_req   = tbl[i].lsr;
         ls_we    = tbl[i].we;
         ls_addr  = tbl[i].lsa;
         ls_wdata = tbl[i].wd;
         @(negedge clk);
         exp = {tbl[i].flags, tbl[i].ma, tbl[i].mwd, tbl[i].ifrd, tbl[i].lsrd, tbl[i].dd};
         check($sformatf("vec%0d_lat%0d", i, tbl[i].g + 1), outv(tbl[i].g), exp);
      end

      // Hand sequence: LS read on MEM_LAT=2, bounded wait for the data pulse.
      do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40;
      @(negedge clk);
      check("seq_ls_gnt", 155'(ls_gnt[1]), 155'(1));
      @(posedge clk);
      #1;
      ls_req = 1'b0;
      cyc = 1;
      while (!ls_rv[1] && cyc < 10) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("seq_rvalid_cycle", 155'(cyc), 155'(3));
      check("seq_rdata", 155'(ls_rdata[1]), 155'(32'hA5A00020));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
